// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes, FSM
// encoding and the expected-parity helper.
package uart_pkg;

  localparam int PAR_NONE      = 0;
  localparam int PAR_EVEN      = 1;
  localparam int PAR_ODD       = 2;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // Zero-extending a narrower word does not change its XOR reduction.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] d, input int mode);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Rx pin synchroniser (flops preset to idle-high) plus, when UART_RX_MAJORITY_EN
// is defined, a 2-of-3 vote over the current and two previous synchronised samples.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_bit
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_rx;
      r_s2 <= r_s1;
    end
  end

  assign o_rx_s = r_s2;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], r_s2};
    end
  end

  assign o_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_s2) | (r_hist[0] & r_s2);
`else
  assign o_bit = r_s2;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with a one-deep valid/ready output register.
// Optional UART_RX_MAJORITY_EN: 2-of-3 bit voting, decisions one cycle later.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 32,
  parameter int PARITY_MODE  = PAR_EVEN,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_PT = CLKS_PER_BIT / 2;
`else
  localparam int START_PT = CLKS_PER_BIT / 2 - 1;
`endif

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_done;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr_q;
  logic                 r_ferr_q;
  logic                 r_ovr;

  logic w_rx_s;
  logic w_bit;
  logic w_tick_start;
  logic w_tick_bit;
  logic w_last_data;
  logic w_last_stop;
  logic w_shift_en;
  logic w_par_en;
  logic w_stop_en;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_rx   (rx),
    .o_rx_s (w_rx_s),
    .o_bit  (w_bit)
  );

  assign w_tick_start = (r_cnt == CNT_W'(START_PT));
  assign w_tick_bit   = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_last_data  = (r_idx == IDX_W'(DATA_BITS - 1));
  assign w_last_stop  = (r_idx == IDX_W'(STOP_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:      if (!w_rx_s) w_next = ST_START;
      ST_START:     if (w_tick_start) w_next = w_bit ? ST_IDLE : ST_DATA;
      ST_DATA:      if (w_tick_bit && w_last_data)
                      w_next = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (w_tick_bit) w_next = ST_STOP;
      // A low final stop bit means a break or misframe: wait for the line to idle.
      ST_STOP:      if (w_tick_bit && w_last_stop) w_next = w_bit ? ST_IDLE : ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (w_rx_s) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != ST_IDLE);
    w_shift_en = (r_state == ST_DATA)   && w_tick_bit;
    w_par_en   = (r_state == ST_PARITY) && w_tick_bit;
    w_stop_en  = (r_state == ST_STOP)   && w_tick_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_stop_en && w_last_stop;
      unique case (r_state)
        ST_IDLE, ST_WAIT_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
        end
        ST_START: begin
          r_cnt  <= w_tick_start ? '0 : r_cnt + 1'b1;
          r_perr <= 1'b0;
          r_ferr <= 1'b0;
        end
        default:  r_cnt <= w_tick_bit ? '0 : r_cnt + 1'b1;
      endcase
      if (w_shift_en) begin
        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
        r_idx   <= w_last_data ? '0 : r_idx + 1'b1;
      end
      if (w_par_en) begin
        r_perr <= (w_bit != parity_bit(MAX_DATA_BITS'(r_shift), PARITY_MODE));
      end
      if (w_stop_en) begin
        r_idx <= r_idx + 1'b1;
        if (!w_bit) r_ferr <= 1'b1;
      end
    end
  end

  // Completion: load when empty or being drained this cycle, otherwise drop and flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_q <= 1'b0;
      r_ferr_q <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (r_done) begin
        if (!r_valid || data_ready) begin
          r_valid  <= 1'b1;
          r_data   <= r_shift;
          r_perr_q <= r_perr;
          r_ferr_q <= r_ferr;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign parity_err = r_perr_q;
  assign frame_err  = r_ferr_q;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (even parity, odd parity,
// no parity with two stop bits) driven from a vector table plus corner sequences.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CPB = 32;

  typedef struct {
    int          sel;
    logic [15:0] bits;
    logic [7:0]  d;
    logic        p;
    logic        f;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxv  [3];
  logic       rdy  [3];
  logic [7:0] dout [3];
  logic       vld  [3];
  logic       perr [3];
  logic       ferr [3];
  logic       ovr  [3];
  logic       busy [3];

  int n_chk     = 0;
  int n_fail    = 0;
  int ovr_cnt_a = 0;

  vec_t vecs [10];

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(PAR_EVEN), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .rx(rxv[0]), .data_out(dout[0]), .data_valid(vld[0]),
    .data_ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(busy[0]));

  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(PAR_ODD), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .rx(rxv[1]), .data_out(dout[1]), .data_valid(vld[1]),
    .data_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .busy(busy[1]));

  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(PAR_NONE), .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .rx(rxv[2]), .data_out(dout[2]), .data_valid(vld[2]),
    .data_ready(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]), .busy(busy[2]));

  always @(negedge clk) if (ovr[0]) ovr_cnt_a++;

  // Serial frame, LSB first from bit 0: start, data, optional parity, stops, idle ones.
  function automatic logic [15:0] frame(input logic [7:0] d, input bit has_par, input logic p,
                                        input int nstop, input logic [1:0] st);
    logic [15:0] f;
    int k;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    k = 9;
    if (has_par) begin
      f[9] = p;
      k    = 10;
    end
    for (int s = 0; s < nstop; s++) f[k+s] = st[s];
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input int sel, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rxv[sel] = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic accept(input int sel);
    rdy[sel] = 1'b1;
    @(negedge clk);
    rdy[sel] = 1'b0;
  endtask

  task automatic check_word(input int sel, input logic [7:0] d, input logic p, input logic f);
    chk("valid", 32'(vld[sel]), 32'd1);
    chk("data", 32'(dout[sel]), 32'(d));
    chk("parity_err", 32'(perr[sel]), 32'(p));
    chk("frame_err", 32'(ferr[sel]), 32'(f));
    chk("busy_idle", 32'(busy[sel]), 32'd0);
    repeat (3) @(negedge clk);
    chk("valid_held", 32'(vld[sel]), 32'd1);
    chk("data_held", 32'(dout[sel]), 32'(d));
    accept(sel);
    chk("valid_drop", 32'(vld[sel]), 32'd0);
  endtask

  initial begin
    int base;
    bit seen;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rxv[i] = 1'b1;
      rdy[i] = 1'b0;
    end

    vecs[0] = '{0, frame(8'h90, 1, 1'b0, 1, 2'b11), 8'h90, 1'b0, 1'b0};
    vecs[1] = '{0, frame(8'h75, 1, 1'b0, 1, 2'b11), 8'h75, 1'b1, 1'b0};
    vecs[2] = '{1, frame(8'h75, 1, 1'b0, 1, 2'b11), 8'h75, 1'b0, 1'b0};
    vecs[3] = '{1, frame(8'h90, 1, 1'b0, 1, 2'b11), 8'h90, 1'b1, 1'b0};
    vecs[4] = '{0, frame(8'h3C, 1, 1'b0, 1, 2'b11), 8'h3C, 1'b0, 1'b0};
    vecs[5] = '{0, frame(8'hFF, 1, 1'b1, 1, 2'b11), 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{2, frame(8'hA5, 0, 1'b0, 2, 2'b11), 8'hA5, 1'b0, 1'b0};
    vecs[7] = '{2, frame(8'h0F, 0, 1'b0, 2, 2'b10), 8'h0F, 1'b0, 1'b1};
    vecs[8] = '{2, frame(8'hF0, 0, 1'b0, 2, 2'b01), 8'hF0, 1'b0, 1'b1};
    vecs[9] = '{0, frame(8'h01, 1, 1'b1, 1, 2'b00), 8'h01, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", 32'(vld[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_data", 32'(dout[i]), 32'd0);
      chk("rst_flags", {29'd0, perr[i], ferr[i], ovr[i]}, 32'd0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      send_bits(vecs[v].sel, vecs[v].bits, 16);
      check_word(vecs[v].sel, vecs[v].d, vecs[v].p, vecs[v].f);
    end

    // Stop bit low for two bit periods: word delivered, receiver parks until idle.
    send_bits(0, frame(8'h5A, 1, 1'b0, 2, 2'b00), 12);
    chk("break_busy", 32'(busy[0]), 32'd1);
    chk("break_valid", 32'(vld[0]), 32'd1);
    chk("break_ferr", 32'(ferr[0]), 32'd1);
    chk("break_data", 32'(dout[0]), 32'h5A);
    rxv[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk("break_busy_low", 32'(busy[0]), 32'd0);
    accept(0);
    send_bits(0, frame(8'h90, 1, 1'b0, 1, 2'b11), 16);
    check_word(0, 8'h90, 1'b0, 1'b0);

    // 100 ns low glitch in idle.
    rxv[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_busy", 32'(busy[0]), 32'd1);
    rxv[0] = 1'b1;
    repeat (11) @(negedge clk);
    chk("glitch_busy_low", 32'(busy[0]), 32'd0);
    repeat (CPB * 12) @(negedge clk);
    chk("glitch_no_valid", 32'(vld[0]), 32'd0);

    // Back-to-back frames with the output register full.
    base = ovr_cnt_a;
    send_bits(0, frame(8'h11, 1, 1'b0, 1, 2'b11), 11);
    send_bits(0, frame(8'h22, 1, 1'b0, 1, 2'b11), 11);
    repeat (4) @(negedge clk);
    chk("ovr_count", 32'(ovr_cnt_a - base), 32'd1);
    chk("ovr_keep_valid", 32'(vld[0]), 32'd1);
    chk("ovr_keep_data", 32'(dout[0]), 32'h11);
    accept(0);
    chk("ovr_drain", 32'(vld[0]), 32'd0);

    // Ready asserted exactly in the completion cycle: new word replaces old, no overrun.
    send_bits(0, frame(8'h33, 1, 1'b0, 1, 2'b11), 11);
    chk("coin_first", 32'(dout[0]), 32'h33);
    base = ovr_cnt_a;
    fork
      send_bits(0, frame(8'h44, 1, 1'b0, 1, 2'b11), 11);
      begin
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
          @(negedge clk);
          if (busy[0]) seen = 1'b1;
        end
        chk("coin_busy_rise", 32'(seen), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
          @(negedge clk);
          if (!busy[0]) seen = 1'b1;
        end
        chk("coin_busy_fall", 32'(seen), 32'd1);
        accept(0);
      end
    join
    repeat (4) @(negedge clk);
    chk("coin_no_ovr", 32'(ovr_cnt_a - base), 32'd0);
    chk("coin_valid", 32'(vld[0]), 32'd1);
    chk("coin_data", 32'(dout[0]), 32'h44);
    accept(0);

    // Reset mid-DATA on the two-stop, no-parity receiver.
    send_bits(2, frame(8'hA5, 0, 1'b0, 2, 2'b11), 5);
    chk("mid_busy", 32'(busy[2]), 32'd1);
    rst    = 1'b1;
    rxv[2] = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy[2]), 32'd0);
    chk("mid_rst_valid", 32'(vld[2]), 32'd0);
    chk("mid_rst_data", 32'(dout[2]), 32'd0);
    chk("mid_rst_flags", {29'd0, perr[2], ferr[2], ovr[2]}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (CPB * 12) @(negedge clk);
    chk("mid_no_output", 32'(vld[2]), 32'd0);
    send_bits(2, frame(8'hA5, 0, 1'b0, 2, 2'b11), 16);
    check_word(2, 8'hA5, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
